// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller.
// Holds the opcode and funct constants, the ALU operation codes, the controller
// state encoding, the mux select codes and the operation classes that the ALU
// decoder understands.
package cpu_ctrl_pkg;

   // Instruction opcodes, instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // R-type function codes, instr[5:0]
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_LUI = 3'b011,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_op_e;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_RTEX   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_IMMEX  = 4'd9,
      ST_IMMWB  = 4'd10,
      ST_JUMP   = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      SRCB_REG   = 2'b00,
      SRCB_FOUR  = 2'b01,
      SRCB_IMM   = 2'b10,
      SRCB_BROFF = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_ALUOUT = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pc_src_e;

   // What the ALU is being asked to do this cycle, as seen by the decoder
   typedef enum logic [1:0] {
      ACLS_ADD   = 2'b00,
      ACLS_SUB   = 2'b01,
      ACLS_RTYPE = 2'b10,
      ACLS_IMM   = 2'b11
   } alu_class_e;

   // Immediate forms that take a zero-extended operand
   function automatic logic imm_is_zext(input logic [5:0] op);
      return (op == OP_ORI) || (op == OP_LUI);
   endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decoder for the multicycle controller.
// Maps the controller's operation class plus the instruction fields onto the
// 3-bit ALU op. For R-type execution it also flags function codes that the
// datapath does not implement.
//   alu_class      in  2  operation class selected by the controller state
//   opcode         in  6  instr[31:26]
//   funct          in  6  instr[5:0]
//   alu_op         out 3  ALU operation code
//   illegal_funct  out 1  funct not supported (meaningful for R-type only)
module alu_decoder
   import cpu_ctrl_pkg::*;
(
   input  alu_class_e  alu_class,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   output logic [2:0]  alu_op,
   output logic        illegal_funct
);

   always_comb begin
      alu_op        = ALU_ADD;
      illegal_funct = 1'b0;
      case (alu_class)
         ACLS_ADD: alu_op = ALU_ADD;
         ACLS_SUB: alu_op = ALU_SUB;
         ACLS_RTYPE: begin
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: illegal_funct = 1'b1;
            endcase
         end
         ACLS_IMM: begin
            case (opcode)
               OP_ORI:  alu_op = ALU_OR;
               OP_LUI:  alu_op = ALU_LUI;
               default: alu_op = ALU_ADD;
            endcase
         end
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU main controller.
// Sequences fetch/decode/execute/memory/writeback for each instruction and
// drives every datapath enable, mux select and the ALU op.
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high
//   opcode      in   6  instr[31:26] from the instruction register
//   funct       in   6  instr[5:0] from the instruction register
//   zero        in   1  ALU zero flag, same cycle
//   pc_en       out  1  PC load enable
//   iord        out  1  memory address: 0=PC, 1=ALUOut
//   mem_write   out  1  data memory write strobe
//   ir_write    out  1  instruction register load
//   reg_dst     out  1  write register: 0=rt, 1=rd
//   mem_to_reg  out  1  write data: 0=ALUOut, 1=MDR
//   reg_write   out  1  register file write enable
//   alu_src_a   out  1  0=PC, 1=A
//   alu_src_b   out  2  00=B, 01=4, 10=ext imm, 11=sext imm<<2
//   imm_zext    out  1  1=zero-extend immediate
//   pc_src      out  2  00=ALU result, 01=ALUOut, 10=jump target
//   alu_op      out  3  ALU operation
//   illegal_op  out  1  one-cycle pulse on unknown opcode/funct
//   state_dbg   out  4  current state encoding
//
// state  | meaning
// FETCH  | read instr at PC, PC+4; held 1+MEM_WAIT cycles, IR/PC load on last
// DECODE | dispatch on opcode, precompute branch target
// MEMADR | compute A + sext(imm) for lw/sw
// MEMRD  | read data memory, held 1+MEM_WAIT cycles
// MEMWB  | write MDR to rt
// MEMWR  | write B to data memory
// RTEX   | R-type ALU operation, funct checked here
// ALUWB  | write ALUOut to rd
// BRANCH | compare A,B; load PC from ALUOut when taken
// IMMEX  | immediate ALU operation
// IMMWB  | write ALUOut to rt
// JUMP   | load jump target into PC
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0   // 0..15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        pc_en,
   output logic        iord,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        imm_zext,
   output logic [1:0]  pc_src,
   output logic [2:0]  alu_op,
   output logic        illegal_op,
   output logic [3:0]  state_dbg
);

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   state_e      state;
   logic [3:0]  wait_cnt;
   logic        illegal_q;
   logic        wait_done;

   alu_class_e  alu_class;
   logic        illegal_funct;

   logic        pc_en_raw;
   logic        mem_write_raw;
   logic        ir_write_raw;
   logic        reg_write_raw;

   assign wait_done = (wait_cnt == WAIT_LAST);

   always_comb begin
      case (state)
         ST_BRANCH: alu_class = ACLS_SUB;
         ST_RTEX:   alu_class = ACLS_RTYPE;
         ST_IMMEX:  alu_class = ACLS_IMM;
         default:   alu_class = ACLS_ADD;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_class     (alu_class),
      .opcode        (opcode),
      .funct         (funct),
      .alu_op        (alu_op),
      .illegal_funct (illegal_funct)
   );

   // The wait counter only advances while stalling in FETCH or MEMRD and is
   // zero in every other state, so it is already clear on entry to either.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_FETCH;
         wait_cnt  <= 4'd0;
         illegal_q <= 1'b0;
      end else begin
         wait_cnt  <= 4'd0;
         illegal_q <= 1'b0;
         case (state)
            ST_FETCH: begin
               if (wait_done) state <= ST_DECODE;
               else           wait_cnt <= wait_cnt + 4'd1;
            end
            ST_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW:             state <= ST_MEMADR;
                  OP_RTYPE:                 state <= ST_RTEX;
                  OP_BEQ, OP_BNE:           state <= ST_BRANCH;
                  OP_ADDI, OP_ORI, OP_LUI:  state <= ST_IMMEX;
                  OP_J:                     state <= ST_JUMP;
                  default: begin
                     state     <= ST_FETCH;
                     illegal_q <= 1'b1;
                  end
               endcase
            end
            ST_MEMADR: begin
               if (opcode == OP_LW) state <= ST_MEMRD;
               else                 state <= ST_MEMWR;
            end
            ST_MEMRD: begin
               if (wait_done) state <= ST_MEMWB;
               else           wait_cnt <= wait_cnt + 4'd1;
            end
            ST_RTEX: begin
               if (illegal_funct) begin
                  state     <= ST_FETCH;
                  illegal_q <= 1'b1;
               end else begin
                  state <= ST_ALUWB;
               end
            end
            ST_IMMEX: state <= ST_IMMWB;
            ST_MEMWB, ST_MEMWR, ST_ALUWB,
            ST_BRANCH, ST_IMMWB, ST_JUMP: state <= ST_FETCH;
            default: state <= ST_FETCH;
         endcase
      end
   end

   // Moore decode; pc_en in BRANCH follows the live zero flag.
   always_comb begin
      pc_en_raw     = 1'b0;
      iord          = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write_raw = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      imm_zext      = 1'b0;
      pc_src        = PCSRC_ALU;
      case (state)
         ST_FETCH: begin
            alu_src_b    = SRCB_FOUR;
            ir_write_raw = wait_done;
            pc_en_raw    = wait_done;
         end
         ST_DECODE: alu_src_b = SRCB_BROFF;
         ST_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         ST_MEMRD: iord = 1'b1;
         ST_MEMWB: begin
            mem_to_reg    = 1'b1;
            reg_write_raw = 1'b1;
         end
         ST_MEMWR: begin
            iord          = 1'b1;
            mem_write_raw = 1'b1;
         end
         ST_RTEX: alu_src_a = 1'b1;
         ST_ALUWB: begin
            reg_dst       = 1'b1;
            reg_write_raw = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a = 1'b1;
            pc_src    = PCSRC_ALUOUT;
            pc_en_raw = (opcode == OP_BNE) ? ~zero : zero;
         end
         ST_IMMEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            imm_zext  = imm_is_zext(opcode);
         end
         ST_IMMWB: reg_write_raw = 1'b1;
         ST_JUMP: begin
            pc_src    = PCSRC_JUMP;
            pc_en_raw = 1'b1;
         end
         default: ;
      endcase
   end

   // Strobes are forced low for the whole reset cycle, even before the
   // state register has returned to FETCH.
   assign pc_en      = pc_en_raw & ~reset;
   assign mem_write  = mem_write_raw & ~reset;
   assign ir_write   = ir_write_raw & ~reset;
   assign reg_write  = reg_write_raw & ~reset;
   assign illegal_op = illegal_q & ~reset;
   assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

   typedef struct {
      int         cyc;
      logic [3:0] st;
      logic [2:0] aop;
      logic       chk_aop;
      logic [1:0] psrc;
      logic       chk_psrc;
      logic [3:0] sel;     // {iord, alu_src_a, alu_src_b}
      logic [3:0] sel_m;
      logic       rdst;
      logic       m2r;
      logic       chk_wb;
      logic       zx;
      logic       chk_zx;
   } ev_t;

   localparam int K_IR = 0, K_PC = 1, K_WB = 2, K_MW = 3, K_ILL = 4;

   logic clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic ev_t mk(input int c, input logic [3:0] st);
      ev_t e;
      e.cyc = c; e.st = st;
      e.aop = 3'b000; e.chk_aop = 1'b0;
      e.psrc = 2'b00; e.chk_psrc = 1'b0;
      e.sel = 4'b0000; e.sel_m = 4'b0000;
      e.rdst = 1'b0; e.m2r = 1'b0; e.chk_wb = 1'b0;
      e.zx = 1'b0; e.chk_zx = 1'b0;
      return e;
   endfunction

   task automatic check_ev(input string nm, input int w, input ev_t e, input ev_t a);
      logic ok;
      checks++;
      ok = (a.cyc == e.cyc) && (a.st == e.st)
         && (!e.chk_aop || a.aop == e.aop)
         && (!e.chk_psrc || a.psrc == e.psrc)
         && ((a.sel & e.sel_m) == (e.sel & e.sel_m))
         && (!e.chk_wb || (a.rdst == e.rdst && a.m2r == e.m2r))
         && (!e.chk_zx || a.zx == e.zx);
      if (!ok) begin
         failures++;
         $display("FAIL %s[w%0d]: got cyc=%0d st=%0d aop=%b psrc=%b sel=%b rdst=%b m2r=%b zx=%b; want cyc=%0d st=%0d aop=%b psrc=%b sel=%b/mask %b rdst=%b m2r=%b zx=%b",
                  nm, w, a.cyc, a.st, a.aop, a.psrc, a.sel, a.rdst, a.m2r, a.zx,
                  e.cyc, e.st, e.aop, e.psrc, e.sel, e.sel_m, e.rdst, e.m2r, e.zx);
      end
   endtask

   task automatic unexpected(input string nm, input int w, input int c);
      checks++;
      failures++;
      $display("FAIL %s[w%0d]: pulse at cyc=%0d, want none", nm, w, c);
   endtask

   task automatic chk(input string nm, input int w, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s[w%0d]: got %0d want %0d", nm, w, act, exp);
      end
   endtask

   // Reference ALU op for R-type: {legal, op}
   function automatic logic [3:0] ref_rtype(input logic [5:0] fn);
      case (fn)
         6'b100000: return {1'b1, 3'b010};
         6'b100010: return {1'b1, 3'b110};
         6'b100100: return {1'b1, 3'b000};
         6'b100101: return {1'b1, 3'b001};
         6'b101010: return {1'b1, 3'b111};
         default:   return {1'b0, 3'b000};
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int W = 2 * g;

      logic       reset = 1'b1;
      logic [5:0] opcode = 6'd0;
      logic [5:0] funct = 6'd0;
      logic       zero = 1'b0;
      logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
      logic       alu_src_a, imm_zext, illegal_op;
      logic [1:0] alu_src_b, pc_src;
      logic [2:0] alu_op;
      logic [3:0] state_dbg;
      logic       done = 1'b0;

      ev_t q_ir[$], q_pc[$], q_wb[$], q_mw[$], q_ill[$];
      ev_t a;
      logic [2:0] prev_aop;
      logic [3:0] prev_sel;
      logic       prev_zx;

      multicycle_control #(.MEM_WAIT(W)) dut (
         .clk        (clk),
         .reset      (reset),
         .opcode     (opcode),
         .funct      (funct),
         .zero       (zero),
         .pc_en      (pc_en),
         .iord       (iord),
         .mem_write  (mem_write),
         .ir_write   (ir_write),
         .reg_dst    (reg_dst),
         .mem_to_reg (mem_to_reg),
         .reg_write  (reg_write),
         .alu_src_a  (alu_src_a),
         .alu_src_b  (alu_src_b),
         .imm_zext   (imm_zext),
         .pc_src     (pc_src),
         .alu_op     (alu_op),
         .illegal_op (illegal_op),
         .state_dbg  (state_dbg)
      );

      task automatic push(input int kind, input ev_t e, input int cut);
         if (e.cyc < cut) begin
            case (kind)
               K_IR:    q_ir.push_back(e);
               K_PC:    q_pc.push_back(e);
               K_WB:    q_wb.push_back(e);
               K_MW:    q_mw.push_back(e);
               default: q_ill.push_back(e);
            endcase
         end
      endtask

      // Issue one instruction starting in its first FETCH cycle. Expected
      // strobes come from the per-instruction cycle budget: fetch 1+W,
      // decode 1, then the class-specific tail. A reset at rst_off cuts
      // every strobe at or after that cycle.
      task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int rst_off);
         int t0, d, len, cut;
         ev_t e;
         logic [3:0] r;
         t0 = cyc;
         d  = t0 + W + 1;
         opcode = op; funct = fn; zero = z;
         cut = (rst_off < 0) ? t0 + 1000000 : t0 + rst_off;
         e = mk(t0 + W, 4'd0);
         e.aop = 3'b010; e.chk_aop = 1'b1; e.psrc = 2'b00; e.chk_psrc = 1'b1;
         e.sel = 4'b0001; e.sel_m = 4'b1111;
         push(K_IR, e, cut);
         push(K_PC, e, cut);
         case (op)
            6'b100011: begin
               e = mk(d + 3 + W, 4'd4);
               e.rdst = 1'b0; e.m2r = 1'b1; e.chk_wb = 1'b1;
               push(K_WB, e, cut);
               len = 2 * W + 5;
            end
            6'b101011: begin
               e = mk(d + 2, 4'd5);
               e.sel = 4'b1000; e.sel_m = 4'b1000;
               push(K_MW, e, cut);
               len = W + 4;
            end
            6'b000000: begin
               r = ref_rtype(fn);
               if (r[3]) begin
                  e = mk(d + 2, 4'd7);
                  e.rdst = 1'b1; e.m2r = 1'b0; e.chk_wb = 1'b1;
                  e.aop = r[2:0]; e.chk_aop = 1'b1;
                  e.sel = 4'b0100; e.sel_m = 4'b0111;
                  push(K_WB, e, cut);
                  len = W + 4;
               end else begin
                  e = mk(d + 2, 4'd0);
                  push(K_ILL, e, cut);
                  len = W + 3;
               end
            end
            6'b000100, 6'b000101: begin
               if ((op == 6'b000100) ? z : !z) begin
                  e = mk(d + 1, 4'd8);
                  e.aop = 3'b110; e.chk_aop = 1'b1; e.psrc = 2'b01; e.chk_psrc = 1'b1;
                  e.sel = 4'b0100; e.sel_m = 4'b0111;
                  push(K_PC, e, cut);
               end
               len = W + 3;
            end
            6'b001000, 6'b001101, 6'b001111: begin
               e = mk(d + 2, 4'd10);
               e.rdst = 1'b0; e.m2r = 1'b0; e.chk_wb = 1'b1;
               e.aop = (op == 6'b001000) ? 3'b010 : (op == 6'b001101) ? 3'b001 : 3'b011;
               e.chk_aop = 1'b1;
               e.zx = (op != 6'b001000); e.chk_zx = 1'b1;
               e.sel = 4'b0110; e.sel_m = 4'b0111;
               push(K_WB, e, cut);
               len = W + 4;
            end
            6'b000010: begin
               e = mk(d + 1, 4'd11);
               e.psrc = 2'b10; e.chk_psrc = 1'b1;
               push(K_PC, e, cut);
               len = W + 3;
            end
            default: begin
               e = mk(d + 1, 4'd0);
               push(K_ILL, e, cut);
               len = W + 2;
            end
         endcase
         if (rst_off < 0) begin
            repeat (len) step();
         end else begin
            repeat (rst_off) step();
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("state_after_reset", W, int'(state_dbg), 0);
         end
      endtask

      initial begin
         logic [5:0] ops[10];
         logic [5:0] fns[5];
         logic [5:0] op, fn;
         ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                 6'b000101, 6'b001000, 6'b001101, 6'b001111, 6'b000010};
         fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
         repeat (3) step();
         reset = 1'b0;
         chk("reset_state", W, int'(state_dbg), 0);

         issue(6'b100011, 6'd0, 1'b0, -1);
         issue(6'b101011, 6'd0, 1'b1, -1);
         for (int i = 0; i < 5; i++) issue(6'b000000, fns[i], 1'b0, -1);
         issue(6'b000000, 6'b000111, 1'b0, -1);
         issue(6'b000100, 6'd0, 1'b1, -1);
         issue(6'b000100, 6'd0, 1'b0, -1);
         issue(6'b000101, 6'd0, 1'b1, -1);
         issue(6'b000101, 6'd0, 1'b0, -1);
         issue(6'b001000, 6'd0, 1'b0, -1);
         issue(6'b001101, 6'd0, 1'b0, -1);
         issue(6'b001111, 6'd0, 1'b0, -1);
         issue(6'b000010, 6'd0, 1'b0, -1);
         issue(6'b111111, 6'd0, 1'b0, -1);
         issue(6'b100011, 6'd0, 1'b0, W + 3);
         issue(6'b100011, 6'd0, 1'b0, 2 * W + 4);
         issue(6'b001000, 6'd0, 1'b0, -1);

         for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
            else                           fn = fns[$urandom_range(0, 4)];
            issue(op, fn, 1'($urandom), -1);
         end

         issue(6'b000010, 6'd0, 1'b0, -1);
         reset = 1'b1;
         repeat (3) step();
         chk("q_ir_left", W, q_ir.size(), 0);
         chk("q_pc_left", W, q_pc.size(), 0);
         chk("q_wb_left", W, q_wb.size(), 0);
         chk("q_mw_left", W, q_mw.size(), 0);
         chk("q_ill_left", W, q_ill.size(), 0);
         done = 1'b1;
      end

      always @(negedge clk) begin
         a = mk(cyc, state_dbg);
         a.aop = alu_op; a.psrc = pc_src;
         a.sel = {iord, alu_src_a, alu_src_b};
         a.rdst = reg_dst; a.m2r = mem_to_reg; a.zx = imm_zext;
         if (ir_write) begin
            if (q_ir.size() == 0) unexpected("ir_write", W, cyc);
            else check_ev("ir_write", W, q_ir.pop_front(), a);
         end
         if (pc_en) begin
            if (q_pc.size() == 0) unexpected("pc_en", W, cyc);
            else check_ev("pc_en", W, q_pc.pop_front(), a);
         end
         if (mem_write) begin
            if (q_mw.size() == 0) unexpected("mem_write", W, cyc);
            else check_ev("mem_write", W, q_mw.pop_front(), a);
         end
         if (illegal_op) begin
            if (q_ill.size() == 0) unexpected("illegal_op", W, cyc);
            else check_ev("illegal_op", W, q_ill.pop_front(), a);
         end
         if (reg_write) begin
            // writeback checks the ALU setup of the execute cycle before it
            a.aop = prev_aop; a.sel = prev_sel; a.zx = prev_zx;
            if (q_wb.size() == 0) unexpected("reg_write", W, cyc);
            else check_ev("reg_write", W, q_wb.pop_front(), a);
         end
         prev_aop <= alu_op;
         prev_sel <= {iord, alu_src_a, alu_src_b};
         prev_zx  <= imm_zext;
      end
   end

   initial begin
      int n;
      n = 0;
      while (!(g_inst[0].done && g_inst[1].done) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (!(g_inst[0].done && g_inst[1].done)) begin
         failures++;
         $display("FAIL timeout: stimulus done=%b%b after %0d cycles, want 11",
                  g_inst[1].done, g_inst[0].done, n);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
